// File: rtl/demux4_stream_if.sv
// Stream bundle for demux4_stream: one valid/ready input and four valid/ready
// output channels. The producer/consumer side uses master, the demux uses slave.
interface demux4_stream_if #(
    parameter int WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_sel;
    logic [WIDTH-1:0]      in_data;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [3:0][WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a 1-entry holding register per channel.
// Optional per-channel accepted-transfer counters are enabled by defining DEMUX4_CNT_EN.
module demux4_stream_lane #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    input  logic             clr_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] cnt_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A load wins over a same-edge drain, so a channel with an always-ready
    // consumer can take one word per cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef DEMUX4_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority over a coincident accept.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr_i;
    assign cnt_o      = '0;
`endif
endmodule

module demux4_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux4_stream_if.slave        dmx,
    input  logic                  cnt_clr,
    output logic [3:0][CNT_W-1:0] cnt
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0] load;

    // Only the selected channel gates the input: a stalled target blocks the
    // stream even when other channels are free, which keeps words in order.
    assign dmx.in_ready = !dmx.out_valid[dmx.in_sel] | dmx.out_ready[dmx.in_sel];

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            assign load[i] = dmx.in_valid & dmx.in_ready & (dmx.in_sel == 2'(i));

            demux4_stream_lane #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (load[i]),
                .data_i  (dmx.in_data),
                .ready_i (dmx.out_ready[i]),
                .clr_i   (cnt_clr),
                .valid_o (dmx.out_valid[i]),
                .data_o  (dmx.out_data[i]),
                .cnt_o   (cnt[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_demux4_stream.sv
// Randomized and directed bench for demux4_stream with a queue scoreboard and a
// separate negedge monitor. Counter expectations follow DEMUX4_CNT_EN.
module tb_demux4_stream;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  cnt_clr = 1'b0;
    logic [3:0][CNT_W-1:0] cnt;

    demux4_stream_if #(.WIDTH(WIDTH)) bus();

    demux4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dmx     (bus),
        .cnt_clr (cnt_clr),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference: each channel is a FIFO of words owed to its consumer (at most
    // one deep by construction), plus the last word loaded and an accept count.
    logic [WIDTH-1:0] exp_q [4][$];
    logic [WIDTH-1:0] last_m [4];
    logic [CNT_W-1:0] cnt_m [4];

    bit               pend_valid = 1'b0;
    bit               pend_acc;
    logic [1:0]       pend_sel;
    logic [WIDTH-1:0] pend_data;
    bit               pend_clr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            last_m[i] = '0;
            cnt_m[i]  = '0;
        end
        pend_valid = 1'b0;
    endtask

    // Commit what happened at the edge that just passed.
    task automatic apply_pending();
        if (pend_valid) begin
            if (pend_acc) begin
                exp_q[pend_sel].push_back(pend_data);
                last_m[pend_sel] = pend_data;
            end
`ifdef DEMUX4_CNT_EN
            for (int i = 0; i < 4; i++) begin
                if (pend_clr) cnt_m[i] = '0;
                else if (pend_acc && pend_sel == 2'(i)) cnt_m[i] = cnt_m[i] + 1'b1;
            end
`endif
            pend_valid = 1'b0;
        end
    endtask

    task automatic step(input bit v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                        input logic [3:0] r, input bit c);
        bit exp_rdy;
        @(posedge clk);
        #1;
        apply_pending();
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
        cnt_clr       = c;
        @(negedge clk);
        exp_rdy = (exp_q[s].size() == 0) || r[s];
        chk($sformatf("in_ready sel%0d", s), {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        pend_acc   = v && exp_rdy;
        pend_sel   = s;
        pend_data  = d;
        pend_clr   = c;
        pend_valid = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        cnt_clr       = 1'b0;
        rst_n         = 1'b0;
        model_clear();
        #1;
        chk("rst out_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("rst out_data", bus.out_data, 32'd0);
        chk("rst cnt", {16'd0, cnt}, 32'd0);
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            chk($sformatf("rst in_ready sel%0d", s), {31'd0, bus.in_ready}, 32'd1);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst held out_valid", {28'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out_valid ch%0d", i), {31'd0, bus.out_valid[i]},
                    {31'd0, exp_q[i].size() != 0});
                chk($sformatf("out_data ch%0d", i), {24'd0, bus.out_data[i]}, {24'd0, last_m[i]});
                chk($sformatf("cnt ch%0d", i), {28'd0, cnt[i]}, {28'd0, cnt_m[i]});
                if (bus.out_valid[i] && bus.out_ready[i] && exp_q[i].size() != 0)
                    chk($sformatf("drain ch%0d", i), {24'd0, bus.out_data[i]},
                        {24'd0, exp_q[i].pop_front()});
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
        model_clear();
        do_reset();

        // Routing to each channel with all consumers ready.
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 8'hA0 + 8'(i), 4'b1111, 1'b0);
        step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);

        // Backpressure on channel 2, then simultaneous drain and load.
        step(1'b1, 2'd2, 8'h55, 4'b1011, 1'b0);
        step(1'b1, 2'd2, 8'h66, 4'b1011, 1'b0);
        step(1'b1, 2'd2, 8'h66, 4'b1011, 1'b0);
        step(1'b1, 2'd2, 8'h66, 4'b1111, 1'b0);
        step(1'b0, 2'd2, 8'h00, 4'b1111, 1'b0);

        // Head-of-line: stalled ch1 does not block ch3 but blocks ch1 traffic.
        step(1'b1, 2'd1, 8'h11, 4'b0000, 1'b0);
        step(1'b1, 2'd3, 8'h33, 4'b0000, 1'b0);
        step(1'b1, 2'd1, 8'h12, 4'b0000, 1'b0);
        step(1'b1, 2'd1, 8'h12, 4'b0000, 1'b0);
        step(1'b1, 2'd1, 8'h12, 4'b0010, 1'b0);
        step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);

        // Idle cycles with garbage select/data must change nothing.
        step(1'b0, 2'd3, 8'hFF, 4'b0000, 1'b0);
        step(1'b0, 2'd1, 8'h5A, 4'b1111, 1'b0);

        // Counter wrap on ch0, then clear coincident with an accept.
        step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 2'd0, 8'(i), 4'b1111, 1'b0);
        step(1'b1, 2'd0, 8'hEE, 4'b1111, 1'b1);
        step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
                 4'($urandom), $urandom_range(0, 15) == 0);

        // Reset with all four channels full; nothing may reappear afterwards.
        for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 8'hC0 + 8'(i), 4'b0000, 1'b0);
        step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 8'h00, 4'b1111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux4_stream.md
Name: demux4_stream

Overview:
- 1-to-4 stream demultiplexer, the distributing counterpart to the 4:1 select mux.
- One valid/ready input stream is routed by a 2-bit select to one of four output channels.
- Each output channel has its own 1-entry holding register.
- Sits between a single producer (e.g. decode/issue) and four consumers (e.g. functional-unit queues); provides backpressure per channel.

Parameters:
- WIDTH, 8, data width in bits of in_data and of each output channel.
- CNT_W, 16, width of each per-channel transfer counter (optional feature only).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion sampled by clk.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block accepts the word this cycle.
- in_sel  input  2  target channel 0..3; sampled only when in_valid=1.
- in_data  input  WIDTH  word to route.
- out_valid  output  4  bit i: channel i holds a word.
- out_ready  input  4  bit i: consumer i takes the word this cycle.
- out_data  output  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- cnt_clr  input  1  synchronous clear of all transfer counters.
- cnt  output  4*CNT_W  per-channel accepted-transfer counts; channel i occupies [i*CNT_W +: CNT_W].

Behaviour:
- Reset (rst_n=0, immediate, no clock needed): out_valid=4'b0000, out_data=0, cnt=0. in_ready then follows the combinational rule below; with all channels empty, in_ready=1.
- in_ready = !out_valid[in_sel] | out_ready[in_sel].
  - Combinational from in_sel and out_ready; no dependence on in_valid.
  - Producer must not derive in_valid from in_ready.
- Accept: in_valid & in_ready at a rising edge. reg[in_sel] <= in_data and out_valid[in_sel] <= 1 at that edge.
- Latency: a word accepted at edge N is visible on out_valid/out_data at edge N (registered), one cycle after presentation.
- Drain: out_valid[i] & out_ready[i] at an edge clears out_valid[i], unless channel i is loaded at the same edge.
- Simultaneous drain and load of the same channel: out_valid[i] stays 1 and the new word replaces the old. Full-rate throughput of 1 word/cycle into one channel while its consumer is always ready.
- Full channel with out_ready[i]=0 and in_sel=i: in_ready=0. Input stalls even if other channels are empty; no reordering or bypass.
- Holding: while out_valid[i]=1 and out_ready[i]=0, out_data channel i is stable.
- Data of channels not loaded is never modified. Data of an empty channel holds its last value and is don't-care.
- out_ready[i] while out_valid[i]=0: ignored.
- Reset asserted mid-transfer: every held word is discarded; no output toggles after reset beyond reset values.
- in_sel/in_data when in_valid=0: ignored; no state change.

Optional Feature:
- Macro DEMUX4_CNT_EN.
- Defined:
  - Four CNT_W-bit counters; counter i increments on each accepted input with in_sel=i.
  - Wraps from 2^CNT_W-1 to 0.
  - cnt_clr=1 zeroes all counters at the edge and takes priority over a same-edge increment; result is 0.
  - Reset zeroes all counters.
- Not defined: cnt is driven to constant 0 and cnt_clr is ignored; ports still exist so the bench is unchanged.

Test Plan:
- Reset: hold rst_n=0 mid-clock -> out_valid=0000, out_data=0, cnt=0 immediately; in_ready=1 for any in_sel.
- Routing: out_ready=1111, send 0xA0/0xA1/0xA2/0xA3 with in_sel=0,1,2,3 on consecutive cycles -> each word on its channel one cycle later, other channels' data unchanged, in_ready=1 throughout.
- Backpressure: out_ready[2]=0, send 0x55 then 0x66 to ch2 -> second cycle in_ready=0, out_data ch2 stays 0x55. Raise out_ready[2] -> 0x66 accepted same edge and ch2 shows 0x66, out_valid[2]=1 continuously.
- Head-of-line: ch1 full and stalled, in_sel=3 with ch3 empty -> in_ready=1, accepted. Switch to in_sel=1 -> in_ready=0 until out_ready[1]=1.
- Reset mid-stream: all four channels full, pulse rst_n low -> out_valid=0000, no word reappears after release.
- DEMUX4_CNT_EN with CNT_W=4: 17 accepts to ch0 -> cnt ch0=1 (wrap). cnt_clr=1 coincident with an accept -> 0. Without macro -> cnt=0 always.
